// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared motor types: Hall code table, illegal codes, decoder state enum
package motor_pkg;

    // The two codes a healthy 120-degree Hall sensor set can never produce.
    localparam logic [2:0] HALL_CODE_ALL_LOW  = 3'b000;
    localparam logic [2:0] HALL_CODE_ALL_HIGH = 3'b111;

    localparam logic [2:0] SECTOR_LAST = 3'd5;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } hall_state_e;

    // Hall code {a,b,c} to raw sector; illegal codes return 0 and are filtered with hall_code_legal.
    function automatic logic [2:0] hall_raw_sector(input logic [2:0] code);
        case (code)
            3'b101:  return 3'd0;
            3'b100:  return 3'd1;
            3'b110:  return 3'd2;
            3'b010:  return 3'd3;
            3'b011:  return 3'd4;
            3'b001:  return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic hall_code_legal(input logic [2:0] code);
        return (code != HALL_CODE_ALL_LOW) && (code != HALL_CODE_ALL_HIGH);
    endfunction

    function automatic logic [2:0] sector_inc(input logic [2:0] s);
        return (s == SECTOR_LAST) ? 3'd0 : s + 3'd1;
    endfunction

    function automatic logic [2:0] sector_dec(input logic [2:0] s);
        return (s == 3'd0) ? SECTOR_LAST : s - 3'd1;
    endfunction

    // Apply alignment offset and reverse shift; offsets 6 and 7 mean no offset. Max sum is 13, fits 4 bits.
    function automatic logic [2:0] sector_map(input logic [2:0] raw, input logic [2:0] off, input logic rev);
        logic [3:0] off_eff;
        logic [3:0] sum;
        off_eff = (off > SECTOR_LAST) ? 4'd0 : {1'b0, off};
        sum     = {1'b0, raw} + off_eff + (rev ? 4'd3 : 4'd0);
        if (sum >= 4'd12) begin
            sum = sum - 4'd12;
        end else if (sum >= 4'd6) begin
            sum = sum - 4'd6;
        end
        return sum[2:0];
    endfunction

endpackage

// File: rtl/hall_sync_debounce.sv
// rtl/hall_sync_debounce.sv - 2-FF Hall synchronisers plus stable-count debounce with accept strobe
module hall_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       hall_a_i,
    input  logic       hall_b_i,
    input  logic       hall_c_i,
    output logic [2:0] code_o,
    output logic       accept_o
);

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES);

    logic [2:0]  sync1_q;
    logic [2:0]  sync2_q;
    logic [2:0]  cand_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        changed;
    logic        accept_d;

    // The count saturates at DB_LAST so a held code is accepted once; a change restarts it at 1
    // (the cycle of the change is the first stable cycle). With DEBOUNCE_CYCLES=1 the change itself accepts.
    always_comb begin
        changed  = (sync2_q != cand_q);
        cnt_d    = changed ? 16'd1 : ((cnt_q == DB_LAST) ? cnt_q : cnt_q + 16'd1);
        accept_d = (cnt_d == DB_LAST) && (changed || (cnt_q != DB_LAST));
    end

    // Synchroniser chain, candidate tracking and registered accept strobe/code.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 3'b000;
            sync2_q  <= 3'b000;
            cand_q   <= 3'b000;
            cnt_q    <= 16'd0;
            code_o   <= 3'b000;
            accept_o <= 1'b0;
        end else begin
            sync1_q  <= {hall_a_i, hall_b_i, hall_c_i};
            sync2_q  <= sync1_q;
            cand_q   <= sync2_q;
            cnt_q    <= cnt_d;
            accept_o <= accept_d;
            if (accept_d) begin
                code_o <= sync2_q;
            end
        end
    end

endmodule

// File: rtl/hall_sector_decoder.sv
// rtl/hall_sector_decoder.sv - Hall sensor to 6-step commutation sector decoder with period and stall detection
module hall_sector_decoder
    import motor_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 50,
    parameter int STALL_CYCLES    = 10_000_000,
    parameter int PERIOD_W        = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                hall_a,
    input  logic                hall_b,
    input  logic                hall_c,
    input  logic                enable,
    input  logic                dir_cmd,
    input  logic [2:0]          sector_offset,
    input  logic                clear_fault,
    output logic [2:0]          sector_out,
    output logic                sector_valid,
    output logic                commut_pulse,
    output logic                dir_meas,
    output logic [PERIOD_W-1:0] period_cycles,
    output logic                period_valid,
    output logic                hall_fault,
    output logic                stall,
    output logic                fault_n_out
);

    localparam logic [PERIOD_W-1:0] STALL_LAST = PERIOD_W'(STALL_CYCLES - 1);

    if (CLK_HZ <= 0 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_timing_params
        $error("hall_sector_decoder: CLK_HZ must be positive and DEBOUNCE_CYCLES within 1..65535");
    end
    if (STALL_CYCLES < 2 || (PERIOD_W < 32 && STALL_CYCLES > (2 ** PERIOD_W))) begin : g_bad_stall_params
        $error("hall_sector_decoder: STALL_CYCLES must be >= 2 and STALL_CYCLES-1 must fit in PERIOD_W bits");
    end

    logic [2:0]          code;
    logic                accept;
    hall_state_e         state_q;
    logic [2:0]          raw_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic                seen_pulse_q;

    logic                legal;
    logic [2:0]          raw_new;
    logic                step_fwd;
    logic                step_rev;
    logic                bad_jump;
    logic [2:0]          sector_new;
    logic [2:0]          sector_cur;
    logic [PERIOD_W-1:0] cnt_inc;

    hall_sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk      (clk),
        .reset_n  (reset_n),
        .hall_a_i (hall_a),
        .hall_b_i (hall_b),
        .hall_c_i (hall_c),
        .code_o   (code),
        .accept_o (accept)
    );

    // Classify the freshly accepted code against the last sector; re-accepting the same sector is a no-op.
    always_comb begin
        legal      = hall_code_legal(code);
        raw_new    = hall_raw_sector(code);
        step_fwd   = legal && (raw_new == sector_inc(raw_q));
        step_rev   = legal && (raw_new == sector_dec(raw_q));
        bad_jump   = accept && (!legal || ((raw_new != raw_q) && !step_fwd && !step_rev));
        sector_new = sector_map(raw_new, sector_offset, dir_cmd);
        sector_cur = sector_map(raw_q, sector_offset, dir_cmd);
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    // Decoder FSM with registered outputs: acquisition, commutation tracking, period/stall and fault latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_INIT;
            raw_q         <= 3'd0;
            cnt_q         <= '0;
            seen_pulse_q  <= 1'b0;
            sector_out    <= 3'd0;
            sector_valid  <= 1'b0;
            commut_pulse  <= 1'b0;
            dir_meas      <= 1'b0;
            period_cycles <= '0;
            period_valid  <= 1'b0;
            hall_fault    <= 1'b0;
            stall         <= 1'b0;
        end else begin
            commut_pulse <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (enable && accept && legal) begin
                        state_q      <= ST_RUN;
                        raw_q        <= raw_new;
                        sector_out   <= sector_new;
                        sector_valid <= 1'b1;
                        cnt_q        <= '0;
                        seen_pulse_q <= 1'b0;
                        period_valid <= 1'b0;
                        stall        <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_q      <= ST_INIT;
                        sector_valid <= 1'b0;
                        cnt_q        <= '0;
                        period_valid <= 1'b0;
                        stall        <= 1'b0;
                    end else if (accept && (step_fwd || step_rev)) begin
                        raw_q         <= raw_new;
                        sector_out    <= sector_new;
                        dir_meas      <= step_rev;
                        commut_pulse  <= 1'b1;
                        period_cycles <= cnt_inc;
                        cnt_q         <= '0;
                        seen_pulse_q  <= 1'b1;
                        // A period that spanned a stall is not a meaningful speed sample.
                        period_valid  <= seen_pulse_q && !stall;
                        stall         <= 1'b0;
                    end else if (bad_jump) begin
                        state_q      <= ST_FAULT;
                        hall_fault   <= 1'b1;
                        sector_valid <= 1'b0;
                        period_valid <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == STALL_LAST) begin
                            stall        <= 1'b1;
                            period_valid <= 1'b0;
                        end
                        // Follow offset/direction changes unless stalled, where the sector is frozen.
                        if (!stall) begin
                            sector_out <= sector_cur;
                        end
                    end
                end
                ST_FAULT: begin
                    if (clear_fault) begin
                        state_q    <= ST_INIT;
                        hall_fault <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign fault_n_out = ~(hall_fault | stall);

endmodule
